// File: rtl/sequence_gen_if.sv
// Request/response bundle for sequence_gen: request controls, seed and order
// in, result flags and data out.
interface sequence_gen_if;
    logic        load;
    logic        fibonacci;
    logic        triangle;
    logic        clear;
    logic [15:0] order;
    logic [63:0] data_in;
    logic        done;
    logic        error;
    logic        overflow;
    logic [63:0] data_out;

    modport master (
        output load, fibonacci, triangle, clear, order, data_in,
        input  done, error, overflow, data_out
    );

    modport slave (
        input  load, fibonacci, triangle, clear, order, data_in,
        output done, error, overflow, data_out
    );
endinterface

// File: rtl/sequence_gen.sv
// Fibonacci / triangle sequence generator, one term per cycle, registered flags.
// Define SEQ_GEN_TRIANGLE_EN to include the triangle datapath; otherwise triangle requests fault.
module sequence_gen (
    input  logic          clk,
    input  logic          reset_n,
    sequence_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, FAULT} state_t;

    state_t      state, state_nxt;
    logic [15:0] idx, idx_nxt;
    logic [15:0] order_q, order_nxt;
    logic [63:0] term, term_nxt;
    logic [63:0] prev, prev_nxt;
    logic [63:0] data_q, data_nxt;
    logic        done_q, done_nxt;
    logic        error_q, error_nxt;
    logic        ovf_q, ovf_nxt;
    logic [64:0] sum;
    logic        mode_ok;

`ifdef SEQ_GEN_TRIANGLE_EN
    logic        tri_q, tri_nxt;

    assign mode_ok = bus.fibonacci ^ bus.triangle;
    // Triangle adds the next index (k+1); Fibonacci adds the previous term.
    assign sum = tri_q ? ({1'b0, term} + {49'd0, idx + 16'd1})
                       : ({1'b0, term} + {1'b0, prev});
`else
    assign mode_ok = bus.fibonacci & ~bus.triangle;
    assign sum     = {1'b0, term} + {1'b0, prev};
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        order_nxt = order_q;
        term_nxt  = term;
        prev_nxt  = prev;
        data_nxt  = data_q;
        done_nxt  = done_q;
        error_nxt = error_q;
        ovf_nxt   = ovf_q;
`ifdef SEQ_GEN_TRIANGLE_EN
        tri_nxt   = tri_q;
`endif
        case (state)
            IDLE: begin
                if (bus.load) state_nxt = ARM;
            end
            ARM: begin
                order_nxt = bus.order;
                term_nxt  = bus.data_in;
                prev_nxt  = '0;
                idx_nxt   = '0;
`ifdef SEQ_GEN_TRIANGLE_EN
                tri_nxt   = bus.triangle;
`endif
                if (mode_ok) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = FAULT;
                    error_nxt = 1'b1;
                end
            end
            RUN: begin
                if (idx == order_q) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    data_nxt  = term;
                end else if (sum[64]) begin
                    state_nxt = FAULT;
                    ovf_nxt   = 1'b1;
                    data_nxt  = '0;
                end else begin
                    term_nxt = sum[63:0];
                    prev_nxt = term;
                    idx_nxt  = idx + 16'd1;
                end
            end
            DONE: begin
                if (!bus.load) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Clear overrides whatever the state logic decided this cycle.
        if (bus.clear) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            error_nxt = 1'b0;
            ovf_nxt   = 1'b0;
            data_nxt  = '0;
            idx_nxt   = '0;
            term_nxt  = '0;
            prev_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            order_q <= '0;
            term    <= '0;
            prev    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SEQ_GEN_TRIANGLE_EN
            tri_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            order_q <= order_nxt;
            term    <= term_nxt;
            prev    <= prev_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
            error_q <= error_nxt;
            ovf_q   <= ovf_nxt;
`ifdef SEQ_GEN_TRIANGLE_EN
            tri_q   <= tri_nxt;
`endif
        end
    end

    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.overflow = ovf_q;
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_sequence_gen.sv
// Self-checking bench for sequence_gen: directed table, corner sequences and
// randomized requests against a closed-form / wide-arithmetic reference model.
module tb_sequence_gen;
    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_OVF  = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    sequence_gen_if bus();

    sequence_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fib_m;
        bit          tri_m;
        logic [63:0] s;
        int          n;
        int          kind;
        logic [63:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] flag_vec(input int kind);
        case (kind)
            K_DONE:  return 64'd4;
            K_ERR:   return 64'd2;
            K_OVF:   return 64'd1;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] flags_now();
        return {61'd0, bus.done, bus.error, bus.overflow};
    endfunction

    // Reference: Fibonacci in 65-bit arithmetic, triangle via s + n(n+1)/2.
    task automatic model(input bit f, input bit t, input logic [63:0] s, input int n,
                         output int kind, output logic [63:0] data, output int lat);
        logic [64:0]  a, b, c;
        logic [127:0] tot;
        bit           legal;
`ifdef SEQ_GEN_TRIANGLE_EN
        legal = (f != t);
`else
        legal = f && !t;
`endif
        kind = K_ERR;
        data = '0;
        lat  = 0;
        if (!legal) return;
        kind = K_DONE;
        lat  = n + 1;
        if (f) begin
            a = '0;
            b = {1'b0, s};
            for (int k = 0; k < n; k++) begin
                c = a + b;
                if (c[64]) begin
                    kind = K_OVF;
                    lat  = k + 1;
                    return;
                end
                a = b;
                b = c;
            end
            data = b[63:0];
        end else begin
            tot = {64'd0, s} + 128'(longint'(n) * (n + 1) / 2);
            if (tot[127:64] == '0) begin
                data = tot[63:0];
            end else begin
                kind = K_OVF;
                for (int k = n; k >= 1; k--) begin
                    tot = {64'd0, s} + 128'(longint'(k) * (k + 1) / 2);
                    if (tot[127:64] != '0) lat = k;
                end
            end
        end
    endtask

    task automatic drive(input bit f, input bit t, input logic [63:0] s, input int n);
        bus.load      = 1'b1;
        bus.fibonacci = f;
        bus.triangle  = t;
        bus.data_in   = s;
        bus.order     = 16'(n);
    endtask

    // Passes the ARM and capture edges, then scrambles the request fields
    // and counts edges after capture until a flag appears.
    task automatic await_result(input int budget, output int lat);
        int j = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.order     = 16'($urandom);
        bus.data_in   = {$urandom, $urandom};
        bus.fibonacci = 1'($urandom);
        bus.triangle  = 1'($urandom);
        while (!(bus.done || bus.error || bus.overflow) && j < budget) begin
            @(negedge clk);
            j++;
        end
        lat = j;
    endtask

    task automatic finish_req(input string name, input int ekind, input logic [63:0] edata);
        repeat (2) @(negedge clk);
        check({name, " flags held"}, flags_now(), flag_vec(ekind));
        if (ekind == K_DONE) begin
            check({name, " data held"}, bus.data_out, edata);
            bus.load = 1'b0;
            @(negedge clk);
            check({name, " done dropped"}, flags_now(), 64'd0);
        end else begin
            bus.clear = 1'b1;
            bus.load  = 1'b0;
            @(negedge clk);
            bus.clear = 1'b0;
            check({name, " cleared flags"}, flags_now(), 64'd0);
            check({name, " cleared data"}, bus.data_out, 64'd0);
        end
        @(negedge clk);
    endtask

    task automatic run_vector(input string name, input bit f, input bit t, input logic [63:0] s,
                              input int n, input int ekind, input logic [63:0] edata, input int elat);
        int lat;
        drive(f, t, s, n);
        await_result(n + 8, lat);
        check({name, " flags"}, flags_now(), flag_vec(ekind));
        check({name, " latency"}, 64'(lat), 64'(elat));
        if (ekind != K_ERR) check({name, " data_out"}, bus.data_out, edata);
        finish_req(name, ekind, edata);
    endtask

    initial begin
        int          mk, ml;
        logic [63:0] md;
        int          r, n;
        bit          f, t;
        logic [63:0] s;

        tbl.push_back('{1'b1, 1'b0, 64'd1,   10,  K_DONE, 64'd89});
`ifdef SEQ_GEN_TRIANGLE_EN
        tbl.push_back('{1'b0, 1'b1, 64'd5,   4,   K_DONE, 64'd15});
        tbl.push_back('{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, K_OVF, 64'd0});
`else
        tbl.push_back('{1'b0, 1'b1, 64'd5,   4,   K_ERR,  64'd0});
        tbl.push_back('{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, K_ERR, 64'd0});
`endif
        tbl.push_back('{1'b1, 1'b1, 64'd3,   2,   K_ERR,  64'd0});
        tbl.push_back('{1'b1, 1'b0, 64'd254, 254, K_OVF,  64'd0});
        tbl.push_back('{1'b1, 1'b0, 64'd1,   0,   K_DONE, 64'd1});
        tbl.push_back('{1'b0, 1'b0, 64'd9,   5,   K_ERR,  64'd0});
        tbl.push_back('{1'b1, 1'b0, 64'd2,   3,   K_DONE, 64'd6});
        tbl.push_back('{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, K_DONE, 64'hFFFF_FFFF_FFFF_FFFF});
        tbl.push_back('{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, K_DONE, 64'hFFFF_FFFF_FFFF_FFFF});
        tbl.push_back('{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2, K_OVF, 64'd0});

        bus.load      = 1'b0;
        bus.clear     = 1'b0;
        bus.fibonacci = 1'b0;
        bus.triangle  = 1'b0;
        bus.order     = '0;
        bus.data_in   = '0;
        reset_n       = 1'b0;
        #12;
        check("reset flags", flags_now(), 64'd0);
        check("reset data", bus.data_out, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            // Latency follows from the rules: n+1 for done, 0 for error, first carry step for overflow.
            ml = (tbl[i].kind == K_DONE) ? tbl[i].n + 1 : 0;
            if (tbl[i].kind == K_OVF) model(tbl[i].fib_m, tbl[i].tri_m, tbl[i].s, tbl[i].n, mk, md, ml);
            run_vector($sformatf("vec%0d", i), tbl[i].fib_m, tbl[i].tri_m, tbl[i].s, tbl[i].n,
                       tbl[i].kind, tbl[i].data, ml);
        end

        // Clear on the same edge the run completes.
        run_vector("pre_clear", 1'b1, 1'b0, 64'd2, 3, K_DONE, 64'd6, 4);
        drive(1'b1, 1'b0, 64'd1, 3);
        @(posedge clk);
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b1;
        bus.load  = 1'b0;
        @(negedge clk);
        bus.clear = 1'b0;
        check("clear_at_done flags", flags_now(), 64'd0);
        check("clear_at_done data", bus.data_out, 64'd0);
        @(negedge clk);
        check("clear_at_done idle", flags_now(), 64'd0);

        // Asynchronous reset mid-run, then restart with load already high.
        run_vector("pre_reset", 1'b1, 1'b0, 64'd1, 10, K_DONE, 64'd89, 11);
        drive(1'b1, 1'b0, 64'd7, 200);
        @(posedge clk);
        @(posedge clk);
        repeat (37) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_reset flags", flags_now(), 64'd0);
        check("midrun_reset data", bus.data_out, 64'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 64'd2, 3);
        reset_n = 1'b1;
        await_result(12, ml);
        check("post_reset flags", flags_now(), flag_vec(K_DONE));
        check("post_reset latency", 64'(ml), 64'd4);
        check("post_reset data_out", bus.data_out, 64'd6);
        finish_req("post_reset", K_DONE, 64'd6);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            f = (r == 0) || (r >= 6);
            t = (r == 0) || (r >= 2 && r <= 5);
            n = $urandom_range(0, 30);
            case ($urandom_range(0, 2))
                0:       s = 64'($urandom_range(0, 1000));
                1:       s = {$urandom, $urandom};
                default: s = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 500));
            endcase
            model(f, t, s, n, mk, md, ml);
            run_vector($sformatf("rand%0d", it), f, t, s, n, mk, md, ml);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
